// File: rtl/spi_flash_reader_if.sv
// spi_flash_reader_if: request/response channel between the upstream
// storage-controller path and the SPI flash read engine.
//   master: upstream requester (drives req_valid/req_addr)
//   slave : spi_flash_reader (drives req_ready, response and busy)
interface spi_flash_reader_if;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output busy
    );
endinterface

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: single-word SPI NOR flash read engine (SPI mode 0).
// Accepts a 24-bit byte address, issues a READ transaction and returns one
// 32-bit little-endian word as a one-cycle response pulse.
// Optional feature macro: SPI_FLASH_READER_FAST_READ_EN
//   defined   -> FAST READ (0x0B) with 8 dummy bits, 72 bits per transaction
//   undefined -> READ (0x03), 64 bits per transaction
// CLK_DIV sets the SCK half-period in clk cycles (1..255).
module spi_flash_reader #(
    parameter int CLK_DIV = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    spi_flash_reader_if.slave         bus,
    output logic                      spi_cs_n,
    output logic                      spi_sck,
    output logic                      spi_mosi,
    input  logic                      spi_miso
);

`ifdef SPI_FLASH_READER_FAST_READ_EN
    localparam logic [7:0] CMD        = 8'h0B;
    localparam int         N_BITS     = 72;
    localparam int         DATA_START = 40;
`else
    localparam logic [7:0] CMD        = 8'h03;
    localparam int         N_BITS     = 64;
    localparam int         DATA_START = 32;
`endif

    localparam logic [6:0] LAST_BIT   = 7'(N_BITS - 1);
    localparam logic [6:0] DATA_FIRST = 7'(DATA_START);
    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic        sck_q, sck_d;
    logic        cs_n_q, cs_n_d;
    logic        mosi_q, mosi_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;

    logic        accept;
    logic        div_done;
    logic        in_data;
    logic [4:0]  data_idx;

    // Ready is gated by reset so a request during reset is never taken.
    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign spi_cs_n      = cs_n_q;
    assign spi_sck       = sck_q;
    assign spi_mosi      = mosi_q;

    assign accept   = bus.req_valid && bus.req_ready;
    assign div_done = (div_cnt_q == DIV_LAST);
    assign in_data  = (bit_cnt_q >= DATA_FIRST);
    // Position of the current data bit within the 32 received bits.
    assign data_idx = 5'(bit_cnt_q - DATA_FIRST);

    // Next-state and output computation for the SPI transaction sequencer.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sck_d       = sck_q;
        cs_n_d      = cs_n_q;
        mosi_d      = mosi_q;
        shift_d     = shift_q;
        data_d      = data_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SHIFT;
                    shift_d   = {CMD, bus.req_addr};
                    bit_cnt_d = 7'd0;
                    div_cnt_d = 8'd0;
                    cs_n_d    = 1'b0;
                    sck_d     = 1'b0;
                    mosi_d    = CMD[7];
                    data_d    = 32'd0;
                end
            end

            SHIFT: begin
                if (!div_done) begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end else begin
                    div_cnt_d = 8'd0;
                    if (!sck_q) begin
                        // End of low phase: SCK rises and MISO is sampled.
                        // Bytes land little-endian, each byte MSB first.
                        sck_d = 1'b1;
                        if (in_data) begin
                            data_d[{data_idx[4:3], ~data_idx[2:0]}] = spi_miso;
                        end
                    end else begin
                        // End of high phase: advance to the next bit.
                        sck_d = 1'b0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = HOLD;
                            mosi_d  = 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 7'd1;
                            // Zeros shift in, so MOSI is low for dummy/data bits.
                            shift_d   = {shift_q[30:0], 1'b0};
                            mosi_d    = shift_q[30];
                        end
                    end
                end
            end

            HOLD: begin
                if (!div_done) begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end else begin
                    div_cnt_d   = 8'd0;
                    state_d     = GAP;
                    cs_n_d      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = data_q;
                end
            end

            GAP: begin
                // Minimum chip-select deselect time before the next access.
                if (!div_done) begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end else begin
                    div_cnt_d = 8'd0;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_cnt_q   <= 8'd0;
            bit_cnt_q   <= 7'd0;
            sck_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            shift_q     <= 32'd0;
            data_q      <= 32'd0;
            rsp_data_q  <= 32'd0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sck_q       <= sck_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: two engines (CLK_DIV=1 and CLK_DIV=3), each with a
// behavioural SPI flash model and a scoreboard of expected responses.
module tb_spi_flash_reader;

`ifdef SPI_FLASH_READER_FAST_READ_EN
    localparam logic [7:0] T_CMD    = 8'h0B;
    localparam int         T_N      = 72;
    localparam int         T_DSTART = 40;
`else
    localparam logic [7:0] T_CMD    = 8'h03;
    localparam int         T_N      = 64;
    localparam int         T_DSTART = 32;
`endif
    localparam int T_ALSB = T_DSTART - 32;

    logic        clk;
    logic        rst;
    logic        req_valid [2];
    logic [23:0] req_addr  [2];
    logic [1:0]  req_ready;
    logic [1:0]  busy;
    logic [1:0]  cs_n;
    logic [1:0]  sck;
    logic [1:0]  mosi;
    logic [1:0]  b2b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [23:0] addr;
        logic [31:0] data;
        int          acc;
    } exp_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Flash array contents: a known word at 0x012345, a hash elsewhere.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h012345: return 8'hEF;
            24'h012346: return 8'hBE;
            24'h012347: return 8'hAD;
            24'h012348: return 8'hDE;
            default:    return a[7:0] ^ {a[12:8], a[15:13]} ^ a[23:16] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        return {flash_byte(a + 24'd3), flash_byte(a + 24'd2),
                flash_byte(a + 24'd1), flash_byte(a)};
    endfunction

    function automatic logic [63:0] exp_cap(input logic [23:0] a);
`ifdef SPI_FLASH_READER_FAST_READ_EN
        return {24'd0, T_CMD, a, 8'h00};
`else
        return {32'd0, T_CMD, a};
`endif
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_inst
            localparam int DIV     = (gi == 0) ? 1 : 3;
            localparam int RSP_LAT = 1 + (2 * T_N + 1) * DIV;
            localparam int RDY_LAT = 1 + (2 * T_N + 2) * DIV;

            spi_flash_reader_if bus ();
            logic miso = 1'b1;

            assign bus.req_valid = req_valid[gi];
            assign bus.req_addr  = req_addr[gi];
            assign req_ready[gi] = bus.req_ready;
            assign busy[gi]      = bus.busy;

            spi_flash_reader #(.CLK_DIV(DIV)) u_dut (
                .clk      (clk),
                .rst      (rst),
                .bus      (bus.slave),
                .spi_cs_n (cs_n[gi]),
                .spi_sck  (sck[gi]),
                .spi_mosi (mosi[gi]),
                .spi_miso (miso)
            );

            // Flash model: capture command/address on SCK rise.
            int          bitn = 0;
            int          last_rises = 0;
            logic [63:0] cap = '0;
            logic [63:0] cap_last = '0;
            always @(posedge sck[gi] or posedge cs_n[gi]) begin
                if (cs_n[gi]) begin
                    cap_last   = cap;
                    last_rises = bitn;
                    cap        = '0;
                    bitn       = 0;
                end else begin
                    if (bitn < T_DSTART) cap = {cap[62:0], mosi[gi]};
                    bitn++;
                end
            end

            // Flash model: drive data on SCK fall; 1s outside the data bits.
            always @(negedge sck[gi] or negedge cs_n[gi]) begin
                logic [7:0] fb;
                int         j;
                if (!cs_n[gi] && bitn >= T_DSTART && bitn < T_N) begin
                    j    = bitn - T_DSTART;
                    fb   = flash_byte(cap[T_ALSB +: 24] + 24'(j / 8));
                    miso = fb[7 - (j % 8)];
                end else begin
                    miso = 1'b1;
                end
            end

            // Monitor: scoreboard, latencies and SCK/CS timing.
            exp_t sb [$];
            int   cyc = 0;
            int   prev_acc = 0;
            int   rsp_acc = 0;
            bit   wait_ready = 0;
            bit   c1_pend = 0;
            bit   in_txn = 0;
            bit   abort = 0;
            bit   have_gap = 0;
            int   run = 0;
            int   gap = 0;
            logic prev_sck = 1'b0;
            always @(negedge clk) begin
                exp_t e;
                cyc++;
                if (rst) begin
                    sb.delete();
                    abort      = 1;
                    have_gap   = 0;
                    wait_ready = 0;
                    c1_pend    = 0;
                end else begin
                    if (c1_pend) begin
                        check("cycle1_cs_n", 64'(cs_n[gi]), 64'd0);
                        check("cycle1_mosi", 64'(mosi[gi]), 64'(T_CMD[7]));
                        c1_pend = 0;
                    end
                    if (req_valid[gi] && bus.req_ready) begin
                        e.addr = req_addr[gi];
                        e.data = exp_word(req_addr[gi]);
                        e.acc  = cyc;
                        sb.push_back(e);
                        if (b2b[gi]) check("b2b_accept_gap", 64'(cyc - prev_acc), 64'(RDY_LAT));
                        prev_acc = cyc;
                        c1_pend  = 1;
                    end
                    if (bus.rsp_valid) begin
                        if (sb.size() == 0) begin
                            check("rsp_unexpected", 64'd1, 64'd0);
                        end else begin
                            e = sb.pop_front();
                            $display("inst%0d div%0d addr %06h rsp_data %08h", gi, DIV, e.addr, bus.rsp_data);
                            check("rsp_latency", 64'(cyc - e.acc), 64'(RSP_LAT));
                            check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                            check("mosi_stream", cap_last, exp_cap(e.addr));
                            check("sck_rises", 64'(last_rises), 64'(T_N));
                            check("rsp_cs_n", 64'(cs_n[gi]), 64'd1);
                            rsp_acc    = e.acc;
                            wait_ready = 1;
                        end
                    end
                    if (wait_ready && bus.req_ready) begin
                        check("ready_latency", 64'(cyc - rsp_acc), 64'(RDY_LAT));
                        wait_ready = 0;
                    end
                end
                if (!cs_n[gi]) begin
                    if (!in_txn) begin
                        if (have_gap) check("cs_gap_min", 64'(gap >= DIV), 64'd1);
                        in_txn   = 1;
                        abort    = 0;
                        run      = 1;
                        prev_sck = sck[gi];
                    end else if (sck[gi] == prev_sck) begin
                        run++;
                    end else begin
                        check("sck_phase_len", 64'(run), 64'(DIV));
                        run      = 1;
                        prev_sck = sck[gi];
                    end
                end else begin
                    if (in_txn) begin
                        in_txn = 0;
                        if (!abort) begin
                            check("hold_len", 64'(run), 64'(DIV));
                            have_gap = 1;
                        end
                        gap = 1;
                    end else begin
                        gap++;
                    end
                end
            end
        end
    endgenerate

    task automatic send(input int i, input logic [23:0] a);
        bit ok;
        ok           = 0;
        req_valid[i] = 1'b1;
        req_addr[i]  = a;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[i]) ok = 1;
        end
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input int i);
        bit done;
        done = 0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            if (!busy[i]) done = 1;
        end
        if (!done) check("idle_timeout", 64'd0, 64'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bit ok;
        rst          = 1'b1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        req_addr[0]  = '0;
        req_addr[1]  = '0;
        b2b          = '0;
        repeat (3) @(posedge clk);
        // A request during reset must not be accepted.
        #1 req_valid[0] = 1'b1;
        @(negedge clk);
        check("rst_ready_low", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 64'(req_ready), 64'h3);
        check("reset_cs_n", 64'(cs_n), 64'h3);
        check("reset_sck", 64'(sck), 64'h0);
        check("reset_mosi", 64'(mosi), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_rsp_data", 64'(g_inst[0].bus.rsp_data), 64'd0);
        repeat (20) @(negedge clk);
        check("idle_cs_n", 64'(cs_n), 64'h3);

        // Nominal read, CLK_DIV=1.
        @(posedge clk);
        #1 send(0, 24'h012345);
        wait_idle(0);
        check("known_word", 64'(g_inst[0].bus.rsp_data), 64'hDEADBEEF);

        // CLK_DIV=3, top of address space, then a second access for the gap.
        send(1, 24'hFFFFFF);
        req_valid[1] = 1'b1;
        req_addr[1]  = 24'h000100;
        ok = 0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[1]) ok = 1;
        end
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        wait_idle(1);

        // Back-to-back with req_valid held; address churn while busy.
        req_valid[0] = 1'b1;
        req_addr[0]  = 24'h000000;
        ok = 0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[0]) ok = 1;
        end
        @(posedge clk);
        #1 b2b[0] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            req_addr[0] = 24'($urandom);
            @(posedge clk);
            #1;
        end
        req_addr[0] = 24'h000004;
        ok = 0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[0]) ok = 1;
        end
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        b2b[0] = 1'b0;
        if (!ok) check("b2b_timeout", 64'd0, 64'd1);
        wait_idle(0);

        // Reset in the middle of a transaction.
        send(0, 24'h000ABC);
        repeat (39) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_ready_low", 64'(req_ready[0]), 64'd0);
        @(negedge clk);
        check("midrst_cs_n", 64'(cs_n[0]), 64'd1);
        check("midrst_sck", 64'(sck[0]), 64'd0);
        check("midrst_busy", 64'(busy[0]), 64'd0);
        check("midrst_rsp_data", 64'(g_inst[0].bus.rsp_data), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 64'(req_ready[0]), 64'd1);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1 send(0, 24'h000010);
        wait_idle(0);

        check("sb0_drained", 64'(g_inst[0].sb.size()), 64'd0);
        check("sb1_drained", 64'(g_inst[1].sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
